// File: rtl/din_debounce_sync.sv
// -----------------------------------------------------------------------------
// din_debounce_sync
//   Conditions a raw asynchronous 1-bit input for the downstream positive edge
//   detector. The input passes through a plain flop synchroniser. A new level is
//   only forwarded to dout once the synchronised value has differed from dout
//   for DEBOUNCE_CYCLES consecutive clocks. A change that reverts before then
//   counts as a glitch in a saturating debug counter.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (overrides everything)
//   din_async   raw asynchronous input
//   glitch_clr  synchronous clear of glitch_cnt (wins over a coincident glitch)
//   dout        clean, debounced level (registered)
//   busy        a candidate level change is being qualified (registered)
//   glitch_cnt  number of rejected transitions, saturating at all-ones
// -----------------------------------------------------------------------------
module din_debounce_sync #(
   parameter int   SYNC_STAGES     = 2,     // legal >= 2
   parameter int   DEBOUNCE_CYCLES = 4,     // legal >= 1
   parameter logic RESET_VAL       = 1'b0,
   parameter int   GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                din_async,
   input  logic                glitch_clr,
   output logic                dout,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   sync_out;
   logic                   glitch_evt;

   assign sync_out   = sync_q[SYNC_STAGES-1];
   // A pending change that falls back to the current dout level is a glitch.
   assign glitch_evt = (state == PENDING) && (sync_out == dout);

   // Synchroniser: a bare shift of flops, nothing between stages, so the first
   // flop has a full cycle to resolve metastability.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_async};
      end
   end

   // Qualification FSM. busy is written alongside state so it always equals
   // (state == PENDING) after the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= STABLE;
         cnt        <= '0;
         busy       <= 1'b0;
         dout       <= RESET_VAL;
         glitch_cnt <= '0;
      end else begin
         case (state)
            STABLE: begin
               cnt <= '0;
               if (sync_out != dout) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     // Single-cycle qualification: accept immediately.
                     dout <= sync_out;
                  end else begin
                     state <= PENDING;
                     cnt   <= CNT_W'(1);
                     busy  <= 1'b1;
                  end
               end
            end

            PENDING: begin
               if (sync_out == dout) begin
                  state <= STABLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  dout  <= sync_out;
                  state <= STABLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= STABLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase

         if (glitch_clr) begin
            glitch_cnt <= '0;
         end else if (glitch_evt && (glitch_cnt != {GLITCH_W{1'b1}})) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_din_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_din_debounce_sync
//   Two instances share clk/reset/glitch_clr: u_dut4 with default parameters
//   and u_dut1 with DEBOUNCE_CYCLES=1. A driver issues one stimulus per clock
//   and pushes the reference model's expected outputs into a scoreboard queue;
//   a monitor pops one entry after every rising edge and compares. Directed
//   phases also check the fixed edge-by-edge values from the behaviour rules.
// -----------------------------------------------------------------------------
module tb_din_debounce_sync;

   localparam int SYNC = 2;
   localparam int GMAX = 255;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       din0 = 1'b0;
   logic       din1 = 1'b0;
   logic       glitch_clr = 1'b0;
   logic       dout0, busy0, dout1, busy1;
   logic [7:0] gcnt0, gcnt1;

   always #5 clk = ~clk;

   din_debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(1'b0), .GLITCH_W(8)) u_dut4 (
      .clk(clk), .reset(reset), .din_async(din0), .glitch_clr(glitch_clr),
      .dout(dout0), .busy(busy0), .glitch_cnt(gcnt0)
   );

   din_debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0), .GLITCH_W(8)) u_dut1 (
      .clk(clk), .reset(reset), .din_async(din1), .glitch_clr(glitch_clr),
      .dout(dout1), .busy(busy1), .glitch_cnt(gcnt1)
   );

   // ---------------------------------------------------------------- checking
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       d0;
      logic       b0;
      logic [7:0] g0;
      logic       d1;
      logic       b1;
      logic [7:0] g1;
   } exp_t;

   exp_t sb[$];

   // ------------------------------------------------------- reference model
   // Sync chain as a plain delay line; debounce as "how many consecutive edges
   // has the synchronised level disagreed with dout".
   bit pipe [2][SYNC];
   bit m_dout [2];
   int m_run [2];
   int m_glitch [2];

   function automatic int dc_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic model_step(input bit d0, input bit d1, input bit rst, input bit clr);
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         bit d;
         bit so;
         bit g;
         d = (i == 0) ? d0 : d1;
         if (rst) begin
            for (int k = 0; k < SYNC; k++) pipe[i][k] = 1'b0;
            m_dout[i]   = 1'b0;
            m_run[i]    = 0;
            m_glitch[i] = 0;
         end else begin
            so = pipe[i][SYNC-1];
            g  = 1'b0;
            if (so != m_dout[i]) begin
               m_run[i]++;
               if (m_run[i] == dc_of(i)) begin
                  m_dout[i] = so;
                  m_run[i]  = 0;
               end
            end else begin
               if (m_run[i] > 0) g = 1'b1;
               m_run[i] = 0;
            end
            if (clr) m_glitch[i] = 0;
            else if (g && m_glitch[i] < GMAX) m_glitch[i]++;
            for (int k = SYNC-1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
            pipe[i][0] = d;
         end
      end
      e.d0 = m_dout[0];
      e.b0 = (m_run[0] > 0);
      e.g0 = 8'(m_glitch[0]);
      e.d1 = m_dout[1];
      e.b1 = (m_run[1] > 0);
      e.g1 = 8'(m_glitch[1]);
      sb.push_back(e);
   endtask

   // --------------------------------------------------------------- monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_dout4", dout0, e.d0);
            check("sb_busy4", busy0, e.b0);
            check("sb_glitch4", gcnt0, e.g0);
            check("sb_dout1", dout1, e.d1);
            check("sb_busy1", busy1, e.b1);
            check("sb_glitch1", gcnt1, e.g1);
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic cycle(input bit d0, input bit d1, input bit rst, input bit clr);
      @(negedge clk);
      din0       = d0;
      din1       = d1;
      reset      = rst;
      glitch_clr = clr;
      model_step(d0, d1, rst, clr);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   initial begin
      bit h1q[$];
      bit v;
      int h0, h1;
      bit r0, r1;

      // 1: reset with din high for two edges; sync flops must not capture it.
      cycle(1, 1, 1, 0);
      cycle(1, 1, 1, 0);
      after_edge();
      check("rst_dout", dout0, 0);
      check("rst_busy", busy0, 0);
      check("rst_glitch", gcnt0, 0);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 0, 0);
         after_edge();
         check("rst_sync_clear", busy0, 0);
      end

      // 2: clean rise held 10 cycles.
      for (int k = 1; k <= 10; k++) begin
         cycle(1, 0, 0, 0);
         after_edge();
         check("rise_dout", dout0, (k >= 6) ? 1 : 0);
         check("rise_busy", busy0, (k >= 3 && k <= 5) ? 1 : 0);
      end
      check("rise_glitch", gcnt0, 0);
      for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0);

      // 3: bounce, high for two sampled edges only.
      for (int k = 1; k <= 8; k++) begin
         cycle((k <= 2) ? 1'b1 : 1'b0, 0, 0, 0);
         after_edge();
         check("bounce_busy", busy0, (k == 3 || k == 4) ? 1 : 0);
         check("bounce_dout", dout0, 0);
         if (k >= 5) check("bounce_glitch", gcnt0, 1);
      end

      // 4: saturation with 300 single-cycle pulses, then clear on a glitch edge.
      for (int k = 0; k < 300; k++) begin
         cycle(1, 0, 0, 0);
         cycle(0, 0, 0, 0);
      end
      for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0);
      after_edge();
      check("sat_glitch", gcnt0, 255);
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      after_edge();
      check("clr_pending", busy0, 1);
      cycle(0, 0, 0, 1);
      after_edge();
      check("clr_wins", gcnt0, 0);
      cycle(0, 0, 0, 0);

      // 5: reset on the edge after busy first rises.
      for (int k = 1; k <= 3; k++) cycle(1, 0, 0, 0);
      cycle(1, 0, 1, 0);
      after_edge();
      check("midq_dout", dout0, 0);
      check("midq_busy", busy0, 0);
      for (int k = 1; k <= 8; k++) begin
         cycle(1, 0, 0, 0);
         after_edge();
         check("midq_rel_dout", dout0, (k >= 6) ? 1 : 0);
      end
      for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0);

      // 6: DEBOUNCE_CYCLES=1 instance follows din1 two edges late.
      for (int k = 1; k <= 24; k++) begin
         v = (((k - 1) / 4) % 2 == 0) ? 1'b1 : 1'b0;
         cycle(0, v, 0, 0);
         h1q.push_back(v);
         after_edge();
         check("dc1_dout", dout1, (k >= 3) ? h1q[k-3] : 1'b0);
         check("dc1_busy", busy1, 0);
      end

      // 7: randomized hold lengths, occasional clear and reset.
      h0 = 0; h1 = 0; r0 = 0; r1 = 0;
      for (int n = 0; n < 2000; n++) begin
         if (h0 == 0) begin r0 = ~r0; h0 = $urandom_range(1, 7); end
         if (h1 == 0) begin r1 = ~r1; h1 = $urandom_range(1, 3); end
         h0--;
         h1--;
         cycle(r0, r1, ($urandom_range(0, 299) == 0), ($urandom_range(0, 49) == 0));
      end
      cycle(0, 0, 0, 0);
      after_edge();
      after_edge();
      check("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
